spi_slave_cfg: RTL

//  Parametrised SPI slave: full-duplex word transfer in any CPOL/CPHA mode, selectable bit order.

---
 rtl/spi_slave_cfg.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_cfg.sv
// SPI slave bridging an external MCU master to the internal bus fabric.
// Full-duplex word transfer in any CPOL/CPHA mode; SCLK is oversampled and edge-detected in the clk domain.
module spi_slave_cfg #(
  parameter int                   DATA_SIZE   = 16,
  parameter bit                   CPOL        = 1'b0,
  parameter bit                   CPHA        = 1'b0,
  parameter bit                   MSB_FIRST   = 1'b1,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [DATA_SIZE-1:0] IDLE_WORD   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic [DATA_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_underrun,
  output logic                 busy,
  output logic [0:0]           dbg_state
);

  localparam int             CW   = $clog2(DATA_SIZE);
  localparam logic [CW-1:0]  LAST = CW'(DATA_SIZE - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // Bit that goes on the wire first for a given word.
  function automatic logic first_bit(input logic [DATA_SIZE-1:0] w);
    return MSB_FIRST ? w[DATA_SIZE-1] : w[0];
  endfunction

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_hist;
  logic                   r_cs_hist;

  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_sclk_edge;
  logic                   w_lead;
  logic                   w_trail;
  logic                   w_sample;
  logic                   w_shift;
  logic                   w_cs_fall;
  logic                   w_cs_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_entry;
  logic                   w_abort;

  logic [CW-1:0]          r_bit_cnt;
  logic                   w_act_sample;
  logic                   w_act_shift;
  logic                   w_word_done;
  logic                   w_load;

  logic [DATA_SIZE-1:0]   r_rx_shift;
  logic [DATA_SIZE-1:0]   w_rx_next;
  logic [DATA_SIZE-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_rx_overrun;

  logic [DATA_SIZE-1:0]   r_tx_hold;
  logic                   r_hold_full;
  logic [DATA_SIZE-1:0]   r_tx_word;
  logic [DATA_SIZE-1:0]   w_load_word;
  logic                   w_tx_accept;
  logic                   r_tx_underrun;
  logic [CW-1:0]          w_tx_idx;
  logic                   r_miso;

  // ---------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_hist <= w_sclk_s;
      r_cs_hist   <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign w_sclk_edge = w_sclk_s ^ r_sclk_hist;
  assign w_lead      = w_sclk_edge & (w_sclk_s != CPOL);
  assign w_trail     = w_sclk_edge & (w_sclk_s == CPOL);
  assign w_sample    = CPHA ? w_trail : w_lead;
  assign w_shift     = CPHA ? w_lead  : w_trail;
  assign w_cs_fall   = r_cs_hist & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_hist & w_cs_s;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_entry     = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = S_ACTIVE;
          w_entry     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_act_sample = (r_state == S_ACTIVE) & ~w_cs_rise & w_sample;
  assign w_act_shift  = (r_state == S_ACTIVE) & ~w_cs_rise & w_shift;
  assign w_word_done  = w_act_sample & (r_bit_cnt == LAST);
  assign w_load       = w_entry | w_word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (w_entry || w_abort || w_word_done) begin
      r_bit_cnt <= '0;
    end else if (w_act_sample) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Receive path
  // Valid/ready: a word transfers on any clk where valid and ready are both
  // high; valid, once raised, holds with stable data until that transfer.
  // ---------------------------------------------------------------------
  assign w_rx_next = MSB_FIRST ? {r_rx_shift[DATA_SIZE-2:0], w_mosi_s}
                               : {w_mosi_s, r_rx_shift[DATA_SIZE-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift <= '0;
    end else if (w_entry || w_abort) begin
      r_rx_shift <= '0;
    end else if (w_act_sample) begin
      r_rx_shift <= w_rx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_overrun <= w_word_done & r_rx_valid & ~rx_ready;
      if (w_word_done && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Transmit path: holding register feeds the active word at each load
  // ---------------------------------------------------------------------
  assign w_tx_accept = tx_valid & ~r_hold_full;
  assign w_load_word = r_hold_full ? r_tx_hold : IDLE_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_hold     <= '0;
      r_hold_full   <= 1'b0;
      r_tx_word     <= '0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_underrun <= w_load & ~r_hold_full;
      r_hold_full   <= w_tx_accept | (r_hold_full & ~w_load);
      if (w_tx_accept) begin
        r_tx_hold <= tx_data;
      end
      if (w_load) begin
        r_tx_word <= w_load_word;
      end
    end
  end

  // Wire position k of the word lives at bit k (LSB first) or bit N-1-k.
  assign w_tx_idx = MSB_FIRST ? (LAST - r_bit_cnt) : r_bit_cnt;

  // CPHA=0 presents bit 0 at load time, so the shift edge with bit_cnt==0
  // (the one following the last sample) must not advance the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso <= first_bit(IDLE_WORD);
    end else if (w_abort) begin
      r_miso <= first_bit(IDLE_WORD);
    end else if (w_load && !CPHA) begin
      r_miso <= first_bit(w_load_word);
    end else if (w_act_shift && (CPHA || (r_bit_cnt != '0))) begin
      r_miso <= r_tx_word[w_tx_idx];
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign spi_miso    = r_miso;
  assign spi_miso_oe = (r_state == S_ACTIVE);
  assign busy        = (r_state == S_ACTIVE);
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;
  assign tx_ready    = ~r_hold_full;
  assign tx_underrun = r_tx_underrun;
  assign dbg_state   = r_state;

endmodule
